// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture path.
package i2s_pkg;
  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} rx_state_t;

  localparam int I2S_DW   = 32;
  localparam int I2S_SLOT = 32;

  // Wide enough to count a full frame of 2*SLOT SCLK periods.
  function automatic int bitcnt_width(input int slot);
    return $clog2(2 * slot);
  endfunction
endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a registered rise detect.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic FCLK,
  input  logic Reset,
  input  logic asyncIn,
  output logic syncOut,
  output logic rise
);
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   syncPrev;

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      syncQ    <= '0;
      syncPrev <= 1'b0;
    end else begin
      syncQ    <= {syncQ[SYNC_STAGES-2:0], asyncIn};
      syncPrev <= syncQ[SYNC_STAGES-1];
    end
  end

  assign syncOut = syncQ[SYNC_STAGES-1];
  assign rise    = syncOut & ~syncPrev;
endmodule

// File: rtl/i2s_rx_core.sv
// I2S receiver: brings SCLK/LRCLK/SDIN into FCLK, frames the one-bit-delayed
// stream into left/right slots and presents sample pairs with valid/ready.
module i2s_rx_core
  import i2s_pkg::*;
#(
  parameter int DW          = I2S_DW,
  parameter int SLOT        = I2S_SLOT,
  parameter int SYNC_STAGES = 2
) (
  input  logic          FCLK,
  input  logic          Reset,
  input  logic          SCLK,
  input  logic          LRCLK,
  input  logic          SDIN,
  input  logic          sampReady,
  input  logic          ovrClr,
  output logic [DW-1:0] sampL,
  output logic [DW-1:0] sampR,
  output logic          sampValid,
  output logic          overrun,
  output logic          locked
);
  localparam int CW       = bitcnt_width(SLOT);
  localparam int CNT_MAX  = 2 * SLOT - 1;
  localparam int MIN_SLOT = SLOT / 2;

  logic          unusedSclkS, unusedLrRise, unusedDRise;
  logic          sclkRise, lrS, dS;
  logic          bitVld_p0, lrBit_p0, dBit_p0;
  rx_state_t     state;
  logic          lrPrev;
  logic [CW-1:0] bitCnt;
  logic [31:0]   cntW;
  logic          slotOk;
  logic [DW-1:0] shL, shR, holdL;
  logic [DW-1:0] pairL_p1, pairR_p1;
  logic          pairVld_p1;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncSclk (
    .FCLK(FCLK), .Reset(Reset), .asyncIn(SCLK), .syncOut(unusedSclkS), .rise(sclkRise));
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncLr (
    .FCLK(FCLK), .Reset(Reset), .asyncIn(LRCLK), .syncOut(lrS), .rise(unusedLrRise));
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncD (
    .FCLK(FCLK), .Reset(Reset), .asyncIn(SDIN), .syncOut(dS), .rise(unusedDRise));

  assign cntW = 32'(bitCnt);
  // A boundary that ends a slot shorter than half nominal is treated as an LRCLK glitch.
  assign slotOk = (cntW + 32'd1) >= MIN_SLOT;

  // Close a slot: take the boundary bit (the old channel's LSB), then left-justify short slots.
  function automatic logic [DW-1:0] finalizeSlot(input logic [DW-1:0] sh, input logic d,
                                                  input logic [31:0] cnt);
    logic [DW-1:0] v;
    v = sh;
    if (cnt < DW) v = {sh[DW-2:0], d};
    if (cnt + 32'd1 < DW) v = v << (DW - 1 - cnt);
    return v;
  endfunction

  // Stage p0: capture LRCLK and SDIN together on each SCLK rise
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      bitVld_p0 <= 1'b0;
      lrBit_p0  <= 1'b0;
      dBit_p0   <= 1'b0;
    end else begin
      bitVld_p0 <= sclkRise;
      if (sclkRise) begin
        lrBit_p0 <= lrS;
        dBit_p0  <= dS;
      end
    end
  end

  // Stage p1: framing FSM, slot shift registers and pair assembly
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      state      <= WAIT_SYNC;
      lrPrev     <= 1'b0;
      bitCnt     <= '0;
      locked     <= 1'b0;
      shL        <= '0;
      shR        <= '0;
      holdL      <= '0;
      pairL_p1   <= '0;
      pairR_p1   <= '0;
      pairVld_p1 <= 1'b0;
    end else begin
      pairVld_p1 <= 1'b0;
      if (bitVld_p0) begin
        lrPrev <= lrBit_p0;
        if (lrBit_p0 == lrPrev) begin
          if (cntW != CNT_MAX) bitCnt <= bitCnt + 1'b1;
          if (cntW < DW) begin
            if (state == LEFT)  shL <= {shL[DW-2:0], dBit_p0};
            if (state == RIGHT) shR <= {shR[DW-2:0], dBit_p0};
          end
        end else begin
          bitCnt <= '0;
          case (state)
            WAIT_SYNC: begin
              if (!lrBit_p0 && slotOk) begin
                state  <= LEFT;
                locked <= 1'b1;
              end
            end
            LEFT: begin
              if (lrBit_p0 && slotOk) begin
                holdL <= finalizeSlot(shL, dBit_p0, cntW);
                state <= RIGHT;
              end else begin
                state  <= WAIT_SYNC;
                locked <= 1'b0;
              end
            end
            RIGHT: begin
              if (!lrBit_p0 && slotOk) begin
                pairL_p1   <= holdL;
                pairR_p1   <= finalizeSlot(shR, dBit_p0, cntW);
                pairVld_p1 <= 1'b1;
                state      <= LEFT;
              end else begin
                state  <= WAIT_SYNC;
                locked <= 1'b0;
              end
            end
            default: begin
              state  <= WAIT_SYNC;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Stage p2: output pair register with valid/ready and sticky overrun
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      sampL     <= '0;
      sampR     <= '0;
      sampValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (pairVld_p1 && (!sampValid || sampReady)) begin
        sampL     <= pairL_p1;
        sampR     <= pairR_p1;
        sampValid <= 1'b1;
      end else if (sampValid && sampReady) begin
        sampValid <= 1'b0;
      end
      if (pairVld_p1 && sampValid && !sampReady) overrun <= 1'b1;
      else if (ovrClr)                             overrun <= 1'b0;
    end
  end
endmodule
